// File: rtl/seg7_scan_pkg.sv
// Shared constants for the seg7_scan display multiplexer.
// Glyphs are active-low with seg[0]=a .. seg[6]=g.
package seg7_scan_pkg;

  localparam int NDIG  = 8;
  localparam int IDX_W = 3;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [NDIG-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    digit_enable = ~(NDIG'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Load/display bundle between the display driver and its host.
interface seg7_scan_if;
  import seg7_scan_pkg::*;

  logic            in_valid;
  logic [31:0]     in_data;
  logic [NDIG-1:0] in_dp;
  logic            blank_lz;
  logic [NDIG-1:0] an;
  logic [6:0]      seg;
  logic            dp;
  logic            frame_done;

  modport master (
    output in_valid, in_data, in_dp, blank_lz,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  in_valid, in_data, in_dp, blank_lz,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_dec
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver with frame-synchronous
// double-buffered data and optional leading-zero blanking.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [NDIG-1:0]  pend_dp_q, pend_dp_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [NDIG-1:0]  disp_dp_q, disp_dp_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fdone_q, fdone_d;

  logic             scan_tick;
  logic             frame_end;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_glyph;
  logic [NDIG-1:0]  zero_above;
  logic             blank;

  assign scan_tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = scan_tick && (idx_q == IDX_W'(NDIG - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (scan_tick) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // A load coincident with the frame boundary bypasses pending straight to display
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    fdone_d     = frame_end;
    if (bus.in_valid) begin
      pend_data_d = bus.in_data;
      pend_dp_d   = bus.in_dp;
    end
    if (frame_end) begin
      disp_data_d = bus.in_valid ? bus.in_data : pend_data_q;
      disp_dp_d   = bus.in_valid ? bus.in_dp   : pend_dp_q;
    end
  end

  // zero_above[k] is set when nibbles NDIG-1 down to k are all zero
  always_comb begin
    zero_above = '0;
    zero_above[NDIG-1] = (disp_data_q[4*NDIG-1 -: 4] == 4'h0);
    for (int k = NDIG - 2; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (disp_data_q[4*k +: 4] == 4'h0);
    end
  end

  assign cur_nib = disp_data_q[{idx_q, 2'b00} +: 4];
  assign blank   = bus.blank_lz && (idx_q != '0) && zero_above[idx_q];

  seg7_hex_dec u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_glyph)
  );

  always_comb begin
    an_d  = digit_enable(idx_q);
    seg_d = blank ? SEG_OFF : cur_glyph;
    dp_d  = ~disp_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      fdone_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fdone_q     <= fdone_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed vector table, hand-written
// frame-boundary/reset sequences and randomized traffic against a cycle-count model.
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  localparam logic [6:0] REF_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpv;
    logic        blz;
    int          digit;
    logic [6:0]  expSeg;
    logic        expDp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_if bus ();

  seg7_scan #(.SCAN_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cycles since reset release plus the two data buffers
  int          mT    = 0;
  logic [31:0] mPend = '0;
  logic [31:0] mDisp = '0;
  logic [7:0]  mPdp  = '0;
  logic [7:0]  mDdp  = '0;

  logic [7:0] expAn;
  logic [6:0] expSeg;
  logic       expDp;
  logic       expFd;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0d)", name, act, exp, mT);
    end
  endtask

  task automatic checkOutput();
    checkVal("an", 32'(bus.an), 32'(expAn));
    checkVal("seg", 32'(bus.seg), 32'(expSeg));
    checkVal("dp", 32'(bus.dp), 32'(expDp));
    checkVal("frame_done", 32'(bus.frame_done), 32'(expFd));
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                               input logic [7:0] p, input logic b);
    int k;
    logic [31:0] upper;
    logic boundary;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_dp    = p;
    bus.blank_lz = b;
    k        = (mT / DIV) % 8;
    boundary = (mT % FRAME) == FRAME - 1;
    upper    = mDisp >> (4 * k);
    if (r) begin
      expAn = 8'hFF; expSeg = 7'h7F; expDp = 1'b1; expFd = 1'b0;
    end else begin
      expAn  = ~(8'(1) << k);
      expSeg = (b && k > 0 && upper == 0) ? 7'h7F : REF_GLYPH[upper[3:0]];
      expDp  = ~mDdp[k];
      expFd  = boundary;
    end
    @(posedge clk);
    #1;
    checkOutput();
    if (r) begin
      mT = 0; mPend = '0; mDisp = '0; mPdp = '0; mDdp = '0;
    end else begin
      if (boundary) begin
        mDisp = v ? d : mPend;
        mDdp  = v ? p : mPdp;
      end
      if (v) begin
        mPend = d;
        mPdp  = p;
      end
      mT++;
    end
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, b);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0);
  endtask

  vec_t vecs [12];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dp    = '0;
    bus.blank_lz = 1'b0;

    vecs[0]  = '{32'h1234ABCD, 8'h00, 1'b0, 0, 7'h21, 1'b1};
    vecs[1]  = '{32'h1234ABCD, 8'h00, 1'b0, 7, 7'h79, 1'b1};
    vecs[2]  = '{32'h1234ABCD, 8'h00, 1'b1, 3, 7'h08, 1'b1};
    vecs[3]  = '{32'h000000F0, 8'h00, 1'b1, 7, 7'h7F, 1'b1};
    vecs[4]  = '{32'h000000F0, 8'h00, 1'b1, 2, 7'h7F, 1'b1};
    vecs[5]  = '{32'h000000F0, 8'h00, 1'b1, 1, 7'h0E, 1'b1};
    vecs[6]  = '{32'h000000F0, 8'h00, 1'b1, 0, 7'h40, 1'b1};
    vecs[7]  = '{32'h000000F0, 8'h00, 1'b0, 2, 7'h40, 1'b1};
    vecs[8]  = '{32'h000000F0, 8'h81, 1'b1, 7, 7'h7F, 1'b0};
    vecs[9]  = '{32'h000000F0, 8'h81, 1'b1, 3, 7'h7F, 1'b1};
    vecs[10] = '{32'h89ABCDEF, 8'h81, 1'b0, 4, 7'h03, 1'b1};
    vecs[11] = '{32'h00000000, 8'h01, 1'b1, 0, 7'h40, 1'b0};

    for (int n = 0; n < 12; n++) begin
      logic found;
      found = 1'b0;
      doReset();
      idle(5, vecs[n].blz);
      applyStimulus(1'b0, 1'b1, vecs[n].data, vecs[n].dpv, vecs[n].blz);
      idle(FRAME, vecs[n].blz);
      for (int i = 0; i < FRAME && !found; i++) begin
        if (bus.an == ~(8'(1) << vecs[n].digit)) found = 1'b1;
        else idle(1, vecs[n].blz);
      end
      checkVal("vecDigitFound", 32'(found), 32'd1);
      checkVal("vecSeg", 32'(bus.seg), 32'(vecs[n].expSeg));
      checkVal("vecDp", 32'(bus.dp), 32'(vecs[n].expDp));
    end

    // First frame_done after reset release
    begin
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      doReset();
      idle(1, 1'b0);
      checkVal("anAfterRelease", 32'(bus.an), 32'h0000_00FE);
      n = 1;
      while (!seen && n < 100) begin
        idle(1, 1'b0);
        n++;
        seen = bus.frame_done;
      end
      checkVal("firstFrameDoneCycle", 32'(n), 32'd32);
    end

    // Last write wins, then a load exactly on the boundary
    doReset();
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h11111111, 8'h00, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h22222222, 8'h00, 1'b0);
    while (mT < FRAME) idle(1, 1'b0);
    idle(1, 1'b0);
    checkVal("lastWriteWins", 32'(bus.seg), 32'h24);
    while ((mT % FRAME) != FRAME - 1) idle(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h55555555, 8'h00, 1'b0);
    checkVal("boundaryPulse", 32'(bus.frame_done), 32'd1);
    idle(1, 1'b0);
    checkVal("boundaryLoad", 32'(bus.seg), 32'h12);

    // Reset while digit 5 is lit with pending data
    doReset();
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h9999_9999, 8'hFF, 1'b0);
    while (((mT / DIV) % 8) != 5) idle(1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h7777_7777, 8'hFF, 1'b0);
    checkVal("rstAn", 32'(bus.an), 32'hFF);
    checkVal("rstSeg", 32'(bus.seg), 32'h7F);
    idle(1, 1'b0);
    checkVal("releaseAn", 32'(bus.an), 32'hFE);
    checkVal("releaseSeg", 32'(bus.seg), 32'h40);
    idle(FRAME + 8, 1'b0);
    checkVal("pendingLost", 32'(bus.seg), 32'h40);

    // Randomized traffic
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      logic b;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 8));
      b = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0),
                    d, 8'($urandom), b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
